// File: rtl/des_mem_pkg.sv
// Shared constants and state type for the DES block-RAM front-end.
package des_mem_pkg;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 64;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/block_fetch_if.sv
// RAM read port plus downstream valid/ready stream of block_fetch.
interface block_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              mem_ce0;
  logic [ADDR_W-1:0] mem_addr0;
  logic [DATA_W-1:0] mem_rdata;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    output mem_ce0, mem_addr0, m_valid, m_data,
    input  mem_rdata, m_ready
  );

  modport slave (
    input  mem_ce0, mem_addr0, m_valid, m_data,
    output mem_rdata, m_ready
  );
endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry register FIFO; head is always the output register.
module fetch_fifo2 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;

  assign dout  = head;
  assign empty = (count == 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (push && pop) begin
      if (count == 2'd2) begin
        head <= tail;
        tail <= din;
      end else begin
        head <= din;
      end
    end else if (push) begin
      if (count == 2'd0) head <= din;
      else               tail <= din;
      count <= count + 2'd1;
    end else if (pop) begin
      head  <= tail;
      count <= count - 2'd1;
    end
  end
endmodule

// File: rtl/block_fetch.sv
// Streams num_words RAM words from base_addr (wrapping) onto a valid/ready port.
module block_fetch
  import des_mem_pkg::*;
#(
  parameter int ADDR_W = des_mem_pkg::ADDR_W,
  parameter int DATA_W = des_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  block_fetch_if.master     bus
);
  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   nwords_q;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   delivered;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_dout;

  // Credit check: buffered + in-flight words, net of this cycle's pop, must stay below 2.
  always_comb begin
    pop       = ~fifo_empty & bus.m_ready;
    next_addr = base_q + issued[ADDR_W-1:0];
    issue     = (state == FETCH) && (issued != nwords_q) &&
                (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  end

  assign bus.mem_ce0   = issue;
  assign bus.mem_addr0 = issue ? next_addr : addr_q;
  assign bus.m_valid   = ~fifo_empty;
  assign bus.m_data    = fifo_dout;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      nwords_q  <= '0;
      issued    <= '0;
      delivered <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr_q <= next_addr;
        issued <= issued + 1'b1;
      end
      if (pop) delivered <= delivered + 1'b1;

      case (state)
        IDLE: if (start) begin
          base_q    <= base_addr;
          nwords_q  <= num_words;
          issued    <= '0;
          delivered <= '0;
          state     <= (num_words == '0) ? DONE : FETCH;
        end
        FETCH: if (issue && (issued == nwords_q - 1'b1)) state <= DRAIN;
        DRAIN: if (pop && (delivered == nwords_q - 1'b1)) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (bus.mem_rdata),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_block_fetch.sv
// Directed bench for block_fetch: RAM model holding mem[i]=i plus a queue-based reference.
module tb_block_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic        busy;
  logic        done;

  block_fetch_if #(.ADDR_W(10), .DATA_W(64)) bus ();

  block_fetch #(.ADDR_W(10), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] ram [1024];
  always @(posedge clk or negedge reset) begin
    if (!reset)           bus.mem_rdata <= '0;
    else if (bus.mem_ce0) bus.mem_rdata <= ram[bus.mem_addr0];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: addresses still to be read and words still to be delivered.
  int unsigned iq[$];
  int unsigned dq[$];
  logic [63:0] got[$];
  bit          job_active = 0;
  bit          done_due   = 0;
  int          outstanding = 0;
  int          first_valid_cyc = -1;
  int          done_cyc = -1;
  int          t_start = 0;
  bit          prev_valid = 0;
  bit          prev_pop = 0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 0;
      prev_pop   = 0;
    end else begin
      bit pop;
      int unsigned e;
      pop = bus.m_valid && bus.m_ready;
      if (job_active) begin
        chk(busy === 1'b1, "busy", busy, 1);
        chk(done === done_due, "done", done, done_due);
        if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.m_valid && dq.size() == 0) chk(0, "extra_valid", bus.m_valid, 0);
        if (bus.mem_ce0) begin
          chk((outstanding - int'(pop)) < 2, "ce_credit", outstanding, pop);
          if (iq.size() == 0) chk(0, "extra_read", bus.mem_addr0, 0);
          else begin
            e = iq.pop_front();
            chk(bus.mem_addr0 == e[9:0], "rd_addr", bus.mem_addr0, e);
          end
          outstanding++;
        end
        if (pop && dq.size() != 0) begin
          e = dq.pop_front();
          chk(bus.m_data == 64'(e), "data", bus.m_data, e);
          got.push_back(bus.m_data);
          outstanding--;
          if (dq.size() == 0) done_due = 1;
        end
        if (done) begin
          done_cyc   = cyc;
          job_active = 0;
          done_due   = 0;
        end
      end else begin
        chk(!bus.mem_ce0 && !bus.m_valid && !busy && !done, "idle",
            {bus.mem_ce0, bus.m_valid, busy, done}, 0);
      end
      if (prev_valid && !prev_pop)
        chk(bus.m_valid && bus.m_data == prev_data, "hold", bus.m_data, prev_data);
      prev_valid = bus.m_valid;
      prev_pop   = pop;
      prev_data  = bus.m_data;
    end
  end

  task automatic start_job(input int b, input int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b[9:0];
    num_words = n[10:0];
    t_start   = cyc;
    @(posedge clk);
    iq.delete();
    dq.delete();
    got.delete();
    for (int k = 0; k < n; k++) begin
      iq.push_back((b + k) % 1024);
      dq.push_back((b + k) % 1024);
    end
    outstanding     = 0;
    done_due        = (n == 0);
    first_valid_cyc = -1;
    done_cyc        = -1;
    job_active      = 1;
    #1 start = 1'b0;
  endtask

  task automatic wait_job(input int bound);
    for (int i = 0; i < bound && job_active; i++) @(posedge clk);
    if (job_active) begin
      chk(0, "timeout", dq.size(), 0);
      job_active = 0;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(busy === 1'b0 && done === 1'b0, {nm, "_ctl"}, {busy, done}, 0);
    chk(bus.mem_ce0 === 1'b0 && bus.mem_addr0 === 10'd0, {nm, "_mem"},
        {bus.mem_ce0, bus.mem_addr0}, 0);
    chk(bus.m_valid === 1'b0 && bus.m_data === 64'd0, {nm, "_stream"}, bus.m_data, 0);
  endtask

  task automatic check_got(input string nm, input int unsigned exp[$]);
    chk(got.size() == exp.size(), {nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(got[i] == 64'(exp[i]), nm, got[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] rdy_pat = 32'b1011_0010_0111_0001_1001_1100_0101_1010;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 64'(i);
    reset       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    num_words   = '0;
    bus.m_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic four-word job with fixed latency
    start_job(5, 4);
    wait_job(50);
    check_got("basic", '{5, 6, 7, 8});
    chk(first_valid_cyc - t_start == 3, "first_valid_lat", first_valid_cyc - t_start, 3);
    chk(done_cyc - t_start == 7, "done_lat", done_cyc - t_start, 7);

    // Address wrap at top of memory
    start_job(1022, 4);
    wait_job(50);
    check_got("wrap", '{1022, 1023, 0, 1});

    // Back-pressure from a fixed ready pattern
    start_job(200, 8);
    for (int i = 0; i < 300 && job_active; i++) begin
      @(posedge clk);
      #1 bus.m_ready = rdy_pat[i % 32];
    end
    wait_job(50);
    bus.m_ready = 1'b1;
    check_got("bp", '{200, 201, 202, 203, 204, 205, 206, 207});

    // Empty job
    start_job(7, 0);
    wait_job(20);
    chk(done_cyc - t_start == 1, "zero_done_lat", done_cyc - t_start, 1);
    chk(got.size() == 0, "zero_words", got.size(), 0);

    // Reset mid-job aborts without done
    start_job(100, 10);
    for (int i = 0; i < 100 && got.size() < 3; i++) @(posedge clk);
    #2 reset = 1'b0;
    job_active = 0;
    done_due   = 0;
    iq.delete();
    dq.delete();
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    start_job(0, 2);
    wait_job(50);
    check_got("after_abort", '{0, 1});

    // Start while busy is ignored
    start_job(300, 6);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 10'd50;
    num_words = 11'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_job(50);
    check_got("ignore_start", '{300, 301, 302, 303, 304, 305});

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/block_fetch.md
# block_fetch

Streaming read front-end for the 64-bit × 1024 block RAM that holds DES data blocks. On a `start` command it reads `num_words` consecutive words from the RAM read port, starting at `base_addr` and wrapping at the top of memory. It absorbs the RAM's one-cycle registered read latency and presents the words in address order on a valid/ready stream to the downstream DES core. It sits between the block RAM and the cipher datapath, and back-pressure from the core stalls RAM reads without dropping or duplicating words.

## Interface
- `ADDR_W`, 10: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 64: word width; one DES block per word.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; captured on accepted `start`.
- `num_words`  in  ADDR_W+1  word count, 0..1024; captured on accepted `start`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the job completes.
- `mem_ce0`  out  1  RAM read enable.
- `mem_addr0`  out  ADDR_W  RAM read address.
- `mem_rdata`  in  DATA_W  RAM registered read data, valid the cycle after `mem_ce0`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_W  output word.
- `m_ready`  in  1  downstream accept.

## Operation
- States:
  - IDLE: `start` with `num_words`≠0 → FETCH.
  - IDLE: `start` with `num_words`==0 → DONE.
  - FETCH: after the last read is issued → DRAIN.
  - DRAIN: after the last output handshake → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- `start` outside IDLE is ignored. The captured `base_addr` and `num_words` are unaffected.
- Output buffer is a 2-entry FIFO.
  - A read issues (`mem_ce0`=1) in FETCH when `occupancy + inflight - pop < 2`.
  - `inflight` is 0 or 1: a read issued last cycle.
  - `pop` is `m_valid & m_ready` this cycle.
  - This rule sustains one word per cycle when `m_ready` stays high, and never overflows.
- Data capture: the FIFO writes `mem_rdata` only when `inflight`=1. At all other times `mem_rdata` is ignored; the RAM output register may be zeroed during reset.
- Address: `mem_addr0` = `base_addr` + issued count, modulo 2^ADDR_W. The address wraps from 1023 to 0.
- `mem_addr0` is held at its last value when `mem_ce0`=0.
- Counters:
  - Issued count: ADDR_W+1 bits, stops at `num_words`.
  - Delivered count: ADDR_W+1 bits. The last handshake occurs when delivered = `num_words`-1.
- `m_data` is the FIFO head and `m_valid` = FIFO not empty. Once `m_valid` is high, it and `m_data` stay stable until the handshake.
- Simultaneous FIFO push and pop: occupancy is unchanged and order is preserved.
- The block never issues write commands; the RAM write port is owned elsewhere.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; FIFO and counters clear.
  - `busy`=0, `done`=0, `mem_ce0`=0, `mem_addr0`=0, `m_valid`=0, `m_data`=0.
- Reset asserted mid-job aborts the job: there is no `done` and outputs return to their reset values.
- Latency, with `start` accepted in cycle T and `m_ready`=1:
  - `busy`=1 and first `mem_ce0` in T+1.
  - First `m_valid` in T+3.
  - Word k is on the output in T+3+k.
  - `done` is in the cycle after the final handshake, i.e. T+3+N for an N-word job.
- `num_words`=0: `busy`=1 for one cycle (T+1), `done` in T+1, no reads issued.
- Back-pressure: with `m_ready`=0 at most 2 words are buffered and `mem_ce0` is 0. Reads resume in the same cycle a pop frees space.
- `busy` falls together with `done`. A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `des_mem_pkg`:
  - `ADDR_W`=10, `DATA_W`=64, `MEM_DEPTH`=1024.
  - State enum: IDLE / FETCH / DRAIN / DONE.
- Sub-module `fetch_fifo2`: 2-entry register FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, empty, count.
  - Uses the same `clk` and `reset`.
- Top level: FSM, address and count counters, and the issue-credit logic.

## Test plan
- RAM preloaded with `mem[i]=i`; `base_addr`=5, `num_words`=4, `m_ready`=1 → outputs 5,6,7,8 in consecutive cycles T+3..T+6; `done` at T+7.
- `base_addr`=1022, `num_words`=4 → output addresses 1022,1023,0,1 in order (wrap-around).
- `num_words`=8 with `m_ready` toggling randomly → exactly 8 words in order, no duplicates, FIFO occupancy ≤2, `mem_ce0`=0 whenever occupancy+inflight is 2 with no pop.
- `num_words`=0 → `done` in T+1, `mem_ce0` never asserts, `m_valid` never asserts.
- `reset` pulsed low after 3 of 10 words delivered → all outputs at reset values immediately, no `done`; a new `start` with `base_addr`=0, `num_words`=2 then delivers 0,1 correctly.
- Second `start` pulse while `busy` → ignored; the first job completes with its original count and addresses.
